pio_instr_fetch: RTL and testbench
==================================

Name: pio_instr_fetch

Overview:
- Per-state-machine fetch unit; the read-side companion of the PIO instruction register file.
- Owns the program counter and drives the regfile read address. Samples the combinational instruction returned, then presents it to the executor with a valid/ready handshake.
- Handles jump, program wrap (wrap_bottom..wrap_top) and per-instruction delay cycles.
- Sustains one instruction per cycle when delay is 0 and the executor is always ready.

Parameters:
- ADDR_W, 5, instruction memory address width (32 slots).
- INSTR_W, 16, instruction width.
- DELAY_W, 5, width of the delay field.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- en  in  1  state machine enable.
- restart  in  1  single-cycle pulse; PC <= wrap_bottom.
- wrap_bottom  in  ADDR_W  wrap target.
- wrap_top  in  ADDR_W  wrap source.
- rd_addr  out  ADDR_W  regfile read address (combinational).
- rd_instr  in  INSTR_W  regfile read data (combinational from rd_addr).
- instr  out  INSTR_W  registered instruction to executor.
- instr_valid  out  1  instr is valid.
- instr_ready  in  1  executor has completed instr this cycle.
- jmp_valid  in  1  with instr_ready: completed instr is a taken jump.
- jmp_addr  in  ADDR_W  jump target.
- delay  in  DELAY_W  delay cycles of the completed instr; sampled with instr_ready.
- pc  out  ADDR_W  address of current/next instruction.

Behaviour:
- Reset (rst_n=0 at a clk edge): pc=0, instr=0, instr_valid=0, delay counter=0, state=DISABLED. Reset overrides every other input.
- Target calculation, at accept (instr_valid & instr_ready):
  - jmp_valid ? jmp_addr : (pc==wrap_top ? wrap_bottom : pc+1 mod 2^ADDR_W).
  - Jump beats wrap.
- rd_addr:
  - = target on an accept cycle with delay==0.
  - = pc otherwise.
- States:
  - DISABLED: instr_valid=0. When en=1: instr<=rd_instr (rd_addr=pc), instr_valid<=1, go to RUN. Data appears the cycle after en rises.
  - RUN, no accept: hold instr, pc and instr_valid (stall).
  - RUN, accept with delay==0: pc<=target, instr<=rd_instr at target, stay in RUN, valid stays 1.
  - RUN, accept with delay>0: pc<=target, cnt<=delay, instr_valid<=0, go to DELAY.
  - DELAY: cnt decrements each cycle. On the cycle cnt==1: load instr from pc, instr_valid<=1, go to RUN. Exactly `delay` cycles have instr_valid=0.
- en=0 in any state: next cycle DISABLED, instr_valid=0, cnt=0, pc retained. An accept in the same cycle still updates pc to target.
- restart=1: pc<=wrap_bottom, cnt<=0, instr_valid<=0. Next state is DISABLED if en=0, else a refetch via the DISABLED path.
- Priority: rst_n > restart > en low > accept.
- instr is a snapshot. A regfile write to pc while instr is held does not update instr; the new contents are seen only on the next fetch of that address.
- wrap_bottom > wrap_top is legal; wrap is applied literally.

Optional Feature:
- Macro: PIO_FORCE_INSTR_EN.
- Enabled: adds ports force_valid (in, 1) and force_instr (in, INSTR_W).
  - force_valid is honoured in DISABLED, in DELAY (cancels remaining delay), or in RUN on an accept cycle.
  - Effect next cycle: instr<=force_instr, instr_valid<=1, forced flag set. Works even with en=0.
  - Accept of a forced instr: target = jmp_valid ? jmp_addr : pc. No increment, no wrap.
  - After that accept: return to DISABLED if en=0.
  - force_valid while RUN is stalled is ignored.
- Disabled: ports absent; behaviour as above.

Decomposition:
- Shared package pio_pkg holds:
  - ADDR_W, INSTR_W, DELAY_W constants.
  - fetch_state_t enum {DISABLED, RUN, DELAY}.
- One sub-module: pio_pc_next, combinational target calculation (pc, wrap_top, wrap_bottom, jmp_valid, jmp_addr, forced -> target).

Test Plan:
- Sequential run: regfile[0..3]=0xA000..0xA003, wrap 0..31, en=1, ready=1 -> instr 0xA000,0xA001,0xA002,0xA003 on consecutive cycles, pc 0..3.
- Wrap: wrap_bottom=2, wrap_top=4 -> pc sequence 2,3,4,2,3; jmp_valid with jmp_addr=7 at pc=4 -> pc=7, no wrap.
- Delay: delay=3 on accept at pc=5 -> instr_valid low exactly 3 cycles, then instr=regfile[6].
- Stall and snapshot: hold instr_ready=0 for 4 cycles while regfile[pc] is rewritten 0x1234->0x5678 -> instr stays 0x1234; next fetch of that address returns 0x5678.
- Enable/restart/reset: en drop mid-DELAY -> instr_valid=0 next cycle, pc retained. restart -> pc=wrap_bottom. rst_n=0 mid-RUN -> pc=0, instr=0, valid=0 next edge.
- With PIO_FORCE_INSTR_EN, en=0: force_instr=0xE001 -> instr=0xE001 valid. Accept without jmp -> pc unchanged, return to DISABLED.

Source files
------------

// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared widths and fetch state encoding for the PIO fetch unit
package pio_pkg;

  localparam int ADDR_W  = 5;
  localparam int INSTR_W = 16;
  localparam int DELAY_W = 5;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    RUN      = 2'd1,
    DELAY    = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/pio_pc_next.sv
// rtl/pio_pc_next.sv - next program counter: jump beats wrap, forced instrs do not advance
module pio_pc_next
  import pio_pkg::*;
(
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] wrap_top,
  input  logic [ADDR_W-1:0] wrap_bottom,
  input  logic              jmp_valid,
  input  logic [ADDR_W-1:0] jmp_addr,
  input  logic              forced,
  output logic [ADDR_W-1:0] target
);

  always_comb begin
    target = pc + ADDR_W'(1);
    if (jmp_valid) begin
      target = jmp_addr;
    end else if (forced) begin
      target = pc;
    end else if (pc == wrap_top) begin
      target = wrap_bottom;
    end
  end

endmodule

// File: rtl/pio_instr_fetch.sv
// rtl/pio_instr_fetch.sv - PIO fetch unit: PC, regfile read address, instr handshake, delay
// Optional forced-instruction injection enabled by defining PIO_FORCE_INSTR_EN.
module pio_instr_fetch
  import pio_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic               restart,
  input  logic [ADDR_W-1:0]  wrap_bottom,
  input  logic [ADDR_W-1:0]  wrap_top,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [INSTR_W-1:0] rd_instr,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               jmp_valid,
  input  logic [ADDR_W-1:0]  jmp_addr,
  input  logic [DELAY_W-1:0] delay,
`ifdef PIO_FORCE_INSTR_EN
  input  logic               force_valid,
  input  logic [INSTR_W-1:0] force_instr,
`endif
  output logic [ADDR_W-1:0]  pc
);

  fetch_state_t        state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic                valid_q, valid_d;
  logic [DELAY_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0]   target;
  logic                accept;
  logic                forced;

`ifdef PIO_FORCE_INSTR_EN
  logic forced_q, forced_d;
  logic force_take;
  assign forced = forced_q;
`else
  assign forced = 1'b0;
`endif

  assign accept      = valid_q & instr_ready;
  assign rd_addr     = (accept && delay == '0) ? target : pc_q;
  assign instr       = instr_q;
  assign instr_valid = valid_q;
  assign pc          = pc_q;

  pio_pc_next u_pc_next (
    .pc          (pc_q),
    .wrap_top    (wrap_top),
    .wrap_bottom (wrap_bottom),
    .jmp_valid   (jmp_valid),
    .jmp_addr    (jmp_addr),
    .forced      (forced),
    .target      (target)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
`ifdef PIO_FORCE_INSTR_EN
    forced_d   = accept ? 1'b0 : forced_q;
    force_take = force_valid && (state_q != RUN || accept);
`endif
    if (restart) begin
      pc_d    = wrap_bottom;
      cnt_d   = '0;
      valid_d = 1'b0;
      state_d = DISABLED;
`ifdef PIO_FORCE_INSTR_EN
      forced_d = 1'b0;
    end else if (force_take) begin
      if (accept) pc_d = target;
      instr_d  = force_instr;
      valid_d  = 1'b1;
      cnt_d    = '0;
      state_d  = RUN;
      forced_d = 1'b1;
    end else if (!en && forced_q && !accept) begin
      // a forced instr stays presented until consumed, even while disabled
      state_d = RUN;
`endif
    end else if (!en) begin
      if (accept) pc_d = target;
      valid_d = 1'b0;
      cnt_d   = '0;
      state_d = DISABLED;
    end else begin
      case (state_q)
        DISABLED: begin
          instr_d = rd_instr;
          valid_d = 1'b1;
          state_d = RUN;
        end
        RUN: begin
          if (accept) begin
            pc_d = target;
            if (delay == '0) begin
              instr_d = rd_instr;
            end else begin
              cnt_d   = delay;
              valid_d = 1'b0;
              state_d = DELAY;
            end
          end
        end
        DELAY: begin
          cnt_d = cnt_q - DELAY_W'(1);
          if (cnt_q <= DELAY_W'(1)) begin
            cnt_d   = '0;
            instr_d = rd_instr;
            valid_d = 1'b1;
            state_d = RUN;
          end
        end
        default: state_d = DISABLED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= DISABLED;
      pc_q    <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
`ifdef PIO_FORCE_INSTR_EN
      forced_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
`ifdef PIO_FORCE_INSTR_EN
      forced_q <= forced_d;
`endif
    end
  end

endmodule

// File: tb/tb_pio_instr_fetch.sv
// tb/tb_pio_instr_fetch.sv - scoreboard bench for pio_instr_fetch (PIO_FORCE_INSTR_EN optional)
module tb_pio_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n, en, restart;
  logic [4:0]  wrap_bottom, wrap_top, rd_addr, jmp_addr, pc;
  logic [15:0] rd_instr, instr;
  logic        instr_valid, instr_ready, jmp_valid;
  logic [4:0]  delay;
`ifdef PIO_FORCE_INSTR_EN
  logic        force_valid = 1'b0;
  logic [15:0] force_instr = 16'h0;
`endif

  logic [15:0] mem [32];
  assign rd_instr = mem[rd_addr];

  typedef struct packed {
    logic [4:0]  pc;
    logic [15:0] ins;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int n;

  always #5 clk = ~clk;

  pio_instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .restart     (restart),
    .wrap_bottom (wrap_bottom),
    .wrap_top    (wrap_top),
    .rd_addr     (rd_addr),
    .rd_instr    (rd_instr),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .jmp_valid   (jmp_valid),
    .jmp_addr    (jmp_addr),
    .delay       (delay),
`ifdef PIO_FORCE_INSTR_EN
    .force_valid (force_valid),
    .force_instr (force_instr),
`endif
    .pc          (pc)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [4:0] p, input logic [15:0] i);
    exp_t e;
    e.pc  = p;
    e.ins = i;
    sb.push_back(e);
  endtask

  // Inputs change at negedge; an accept seen here is the one the next posedge takes.
  task automatic tick();
    exp_t e;
    if (instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_accept", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("acc_pc", 32'(pc), 32'(e.pc));
        chk("acc_instr", 32'(instr), 32'(e.ins));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; restart = 1'b0;
    wrap_bottom = 5'd0; wrap_top = 5'd31;
    instr_ready = 1'b0; jmp_valid = 1'b0; jmp_addr = 5'd0; delay = 5'd0;
    for (int i = 0; i < 32; i++) mem[i] = 16'hA000 + 16'(i);
    @(negedge clk);
    tick(); tick();
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_instr", 32'(instr), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);

    // sequential run
    rst_n = 1'b1; en = 1'b1;
    tick();
    chk("fetch_valid", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) push(5'(i), 16'hA000 + 16'(i));
    repeat (4) tick();
    chk("seq_drained", 32'(sb.size()), 32'd0);

    // wrap 2..4 then jump out of the window
    instr_ready = 1'b0; restart = 1'b1; wrap_bottom = 5'd2; wrap_top = 5'd4;
    tick();
    chk("restart_pc", 32'(pc), 32'd2);
    chk("restart_valid", 32'(instr_valid), 32'd0);
    restart = 1'b0;
    tick();
    instr_ready = 1'b1;
    push(5'd2, 16'hA002); push(5'd3, 16'hA003); push(5'd4, 16'hA004);
    push(5'd2, 16'hA002); push(5'd3, 16'hA003);
    repeat (5) tick();
    push(5'd4, 16'hA004);
    jmp_valid = 1'b1; jmp_addr = 5'd7;
    tick();
    jmp_valid = 1'b0;
    push(5'd7, 16'hA007);
    tick();
    chk("jump_drained", 32'(sb.size()), 32'd0);

    // delay of 3 at pc 5
    instr_ready = 1'b0; wrap_bottom = 5'd5; wrap_top = 5'd31; restart = 1'b1;
    tick();
    restart = 1'b0;
    tick();
    instr_ready = 1'b1; delay = 5'd3;
    push(5'd5, 16'hA005);
    tick();
    delay = 5'd0;
    n = 0;
    while (instr_valid !== 1'b1 && n < 10) begin
      n++;
      tick();
    end
    chk("delay_cycles", 32'(n), 32'd3);
    push(5'd6, 16'hA006);
    tick();

    // stall with regfile rewrite under the held instr
    mem[8] = 16'h1234;
    push(5'd7, 16'hA007);
    tick();
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      mem[8] = 16'h5678;
      chk("stall_instr", 32'(instr), 32'h1234);
      chk("stall_pc", 32'(pc), 32'd8);
    end
    instr_ready = 1'b1; jmp_valid = 1'b1; jmp_addr = 5'd8;
    push(5'd8, 16'h1234);
    tick();
    jmp_valid = 1'b0;
    push(5'd8, 16'h5678);
    tick();

    // en drop in the middle of a delay
    delay = 5'd2;
    push(5'd9, 16'hA009);
    tick();
    delay = 5'd0;
    tick();
    en = 1'b0;
    tick();
    chk("en_drop_valid", 32'(instr_valid), 32'd0);
    chk("en_drop_pc", 32'(pc), 32'd10);
    tick();
    chk("disabled_valid", 32'(instr_valid), 32'd0);
    en = 1'b1;
    tick();
    push(5'd10, 16'hA00A);
    tick();

    // inverted wrap window applied literally
    wrap_bottom = 5'd20; wrap_top = 5'd11;
    push(5'd11, 16'hA00B);
    tick();
    push(5'd20, 16'hA014);
    tick();
    wrap_bottom = 5'd0; wrap_top = 5'd31;

    // reset in the middle of RUN
    instr_ready = 1'b0; rst_n = 1'b0;
    tick();
    chk("midrst_pc", 32'(pc), 32'd0);
    chk("midrst_instr", 32'(instr), 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    rst_n = 1'b1;
    tick();
    instr_ready = 1'b1;
    push(5'd0, 16'hA000);
    tick();

`ifdef PIO_FORCE_INSTR_EN
    instr_ready = 1'b0; en = 1'b0;
    tick();
    force_valid = 1'b1; force_instr = 16'hE001;
    tick();
    force_valid = 1'b0;
    chk("force_valid", 32'(instr_valid), 32'd1);
    chk("force_instr", 32'(instr), 32'hE001);
    chk("force_pc", 32'(pc), 32'd1);
    instr_ready = 1'b1;
    push(5'd1, 16'hE001);
    tick();
    chk("force_ret_valid", 32'(instr_valid), 32'd0);
    chk("force_ret_pc", 32'(pc), 32'd1);
    tick();
    chk("force_stay_disabled", 32'(instr_valid), 32'd0);
`endif

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
